// File: rtl/instruction_loader_if.sv
// Byte-stream and instruction-memory write signals of the instruction loader.
// The slave modport is the loader; the master modport is the byte source / memory side.
interface instruction_loader_if #(
  parameter int unsigned BITS_SIZE = 32,
  parameter int unsigned CNT_W     = 7
);
  logic                 i_load_start;
  logic [7:0]           i_rx_data;
  logic                 i_rx_valid;
  logic [BITS_SIZE-1:0] o_instruction_address;
  logic [BITS_SIZE-1:0] o_instruction;
  logic                 o_flag_write_intruc;
  logic                 o_busy;
  logic                 o_load_done;
  logic [CNT_W-1:0]     o_word_count;
  logic                 o_timeout_err;

  modport master (
    output i_load_start, i_rx_data, i_rx_valid,
    input  o_instruction_address, o_instruction, o_flag_write_intruc,
    input  o_busy, o_load_done, o_word_count, o_timeout_err
  );

  modport slave (
    input  i_load_start, i_rx_data, i_rx_valid,
    output o_instruction_address, o_instruction, o_flag_write_intruc,
    output o_busy, o_load_done, o_word_count, o_timeout_err
  );
endinterface

// File: rtl/instruction_loader.sv
// Assembles big-endian UART bytes into words and writes them sequentially to instruction memory.
// Define LOADER_TIMEOUT_EN to discard partial words after TIMEOUT_CYCLES idle cycles.
module instruction_loader #(
  parameter int unsigned          BITS_SIZE      = 32,
  parameter int unsigned          SIZE_TOTAL     = 256,
  parameter logic [BITS_SIZE-1:0] HALT_WORD      = 32'hFFFF_FFFF,
  parameter int unsigned          TIMEOUT_CYCLES = 1000000
) (
  input logic                 i_clk,
  input logic                 i_reset,
  instruction_loader_if.slave bus
);

  localparam int unsigned          CntW     = $clog2(SIZE_TOTAL / 4) + 1;
  localparam logic [BITS_SIZE-1:0] LastAddr = BITS_SIZE'(SIZE_TOTAL - 4);

  typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [23:0]          part_q, part_d;
  logic [BITS_SIZE-1:0] instr_q, instr_d;
  logic [BITS_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [BITS_SIZE-1:0] addr_q, addr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 tmo_err_q, tmo_err_d;
  logic                 tmo_hit;

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            tmo_run;

  // Count only while a partial word is waiting for its next byte.
  assign tmo_run = (state_q == StRecv) && (idx_q != 2'd0) && !bus.i_rx_valid &&
                   !bus.i_load_start;
  assign tmo_hit = tmo_run && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = '0;
    if (tmo_run && !tmo_hit) begin
      tmo_cnt_d = tmo_cnt_q + TmoW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    part_d    = part_q;
    instr_d   = instr_q;
    wr_addr_d = wr_addr_q;
    addr_d    = addr_q;
    count_d   = count_q;
    tmo_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.i_load_start) begin
          state_d = StRecv;
          addr_d  = '0;
          count_d = '0;
          idx_d   = '0;
        end
      end
      StRecv: begin
        if (bus.i_load_start) begin
          addr_d  = '0;
          count_d = '0;
          idx_d   = '0;
        end else if (bus.i_rx_valid) begin
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0: part_d[23:16] = bus.i_rx_data;
            2'd1: part_d[15:8]  = bus.i_rx_data;
            2'd2: part_d[7:0]   = bus.i_rx_data;
            default: begin
              instr_d   = BITS_SIZE'({part_q, bus.i_rx_data});
              wr_addr_d = addr_q;
              state_d   = StWrite;
            end
          endcase
        end else if (tmo_hit) begin
          idx_d     = '0;
          part_d    = '0;
          tmo_err_d = 1'b1;
        end
      end
      StWrite: begin
        // The strobe is combinational on state, so it completes even on a restart.
        addr_d  = (wr_addr_q == LastAddr) ? wr_addr_q : addr_q + BITS_SIZE'(4);
        count_d = count_q + CntW'(1);
        if (bus.i_load_start) begin
          state_d = StRecv;
          addr_d  = '0;
          count_d = '0;
          idx_d   = '0;
        end else if ((instr_q == HALT_WORD) || (wr_addr_q == LastAddr)) begin
          state_d = StDone;
        end else begin
          state_d = StRecv;
          if (bus.i_rx_valid) begin
            part_d[23:16] = bus.i_rx_data;
            idx_d         = 2'd1;
          end
        end
      end
      StDone: begin
        if (bus.i_load_start) begin
          state_d = StRecv;
          addr_d  = '0;
          count_d = '0;
          idx_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      part_q    <= '0;
      instr_q   <= '0;
      wr_addr_q <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      part_q    <= part_d;
      instr_q   <= instr_d;
      wr_addr_q <= wr_addr_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign bus.o_instruction_address = wr_addr_q;
  assign bus.o_instruction         = instr_q;
  assign bus.o_flag_write_intruc   = (state_q == StWrite) && !i_reset;
  assign bus.o_busy                = (state_q == StRecv) || (state_q == StWrite);
  assign bus.o_load_done           = (state_q == StDone);
  assign bus.o_word_count          = count_q;
  assign bus.o_timeout_err         = tmo_err_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: vector table, directed corner cases and
// randomized load sessions compared against a byte-stream-to-writes reference model.
module tb_instruction_loader;

  localparam int unsigned TmoCycles = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_loader_if #(.BITS_SIZE(32), .CNT_W(7)) bus ();

  instruction_loader #(
    .BITS_SIZE      (32),
    .SIZE_TOTAL     (256),
    .HALT_WORD      (32'hFFFF_FFFF),
    .TIMEOUT_CYCLES (TmoCycles)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_addr;
    logic        exp_done;
    logic [6:0]  exp_count;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  stim_q[$];
  vec_t        vecs[3];

  // Every write strobe seen, as {address, word}.
  always @(negedge clk) begin
    if (bus.o_flag_write_intruc === 1'b1) begin
      obs_q.push_back({bus.o_instruction_address, bus.o_instruction});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    tick();
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    bus.i_load_start = 1'b1;
    tick();
    bus.i_load_start = 1'b0;
  endtask

  // Reference: bytes pack big-endian into words at 0,4,8,...; the load ends after
  // the halt word or the 64th word and any later bytes are ignored.
  task automatic build_model();
    logic [31:0] w;
    exp_q.delete();
    for (int n = 0; 4 * n + 3 < stim_q.size(); n++) begin
      w = {stim_q[4*n], stim_q[4*n+1], stim_q[4*n+2], stim_q[4*n+3]};
      exp_q.push_back({32'(4 * n), w});
      if (w == 32'hFFFF_FFFF || n == 63) break;
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, " nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, " addr"}, obs_q[i][63:32], exp_q[i][63:32]);
      check({tag, " word"}, obs_q[i][31:0], exp_q[i][31:0]);
    end
  endtask

  task automatic run_session(input int n_words);
    logic [31:0] w;
    logic        ended;
    pulse_start();
    obs_q.delete();
    stim_q.delete();
    for (int i = 0; i < n_words; i++) begin
      w = $urandom();
      if ($urandom_range(5, 0) == 0) w = 32'hFFFF_FFFF;
      else if (w == 32'hFFFF_FFFF) w = 32'h0;
      for (int k = 3; k >= 0; k--) stim_q.push_back(w[8*k +: 8]);
    end
    for (int k = $urandom_range(3, 0); k > 0; k--) stim_q.push_back(8'($urandom()));
    foreach (stim_q[i]) begin
      send_byte(stim_q[i]);
      idle($urandom_range(2, 0));
    end
    idle(3);
    build_model();
    compare_writes("rand");
    ended = (exp_q.size() == 64) ||
            ((exp_q.size() > 0) && (exp_q[exp_q.size()-1][31:0] == 32'hFFFF_FFFF));
    check("rand count", 32'(bus.o_word_count), 32'(exp_q.size()));
    check("rand done", 32'(bus.o_load_done), 32'(ended));
    check("rand busy", 32'(bus.o_busy), 32'(!ended));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{word: 32'h2001_0005, exp_addr: 32'd0, exp_done: 1'b0, exp_count: 7'd1};
    vecs[1] = '{word: 32'h0000_0000, exp_addr: 32'd4, exp_done: 1'b0, exp_count: 7'd2};
    vecs[2] = '{word: 32'hFFFF_FFFF, exp_addr: 32'd8, exp_done: 1'b1, exp_count: 7'd3};

    bus.i_load_start = 1'b0;
    bus.i_rx_valid   = 1'b0;
    bus.i_rx_data    = 8'h00;
    rst              = 1'b1;
    idle(2);
    rst = 1'b0;

    check("reset addr", bus.o_instruction_address, 32'h0);
    check("reset instr", bus.o_instruction, 32'h0);
    check("reset strobe", 32'(bus.o_flag_write_intruc), 32'h0);
    check("reset busy", 32'(bus.o_busy), 32'h0);
    check("reset done", 32'(bus.o_load_done), 32'h0);
    check("reset count", 32'(bus.o_word_count), 32'h0);
    check("reset tmo", 32'(bus.o_timeout_err), 32'h0);

    // Bytes in IDLE are ignored, including one alongside the start pulse.
    send_word(32'h0102_0304);
    idle(2);
    check("idle nwrites", 32'(obs_q.size()), 32'd0);
    check("idle count", 32'(bus.o_word_count), 32'd0);
    bus.i_rx_data    = 8'hEE;
    bus.i_rx_valid   = 1'b1;
    bus.i_load_start = 1'b1;
    tick();
    bus.i_rx_valid   = 1'b0;
    bus.i_load_start = 1'b0;
    check("start busy", 32'(bus.o_busy), 32'd1);

    // Vector table: strobe one cycle after the 4th byte.
    for (int i = 0; i < 3; i++) begin
      send_word(vecs[i].word);
      @(negedge clk);
      check("vec strobe", 32'(bus.o_flag_write_intruc), 32'd1);
      check("vec addr", bus.o_instruction_address, vecs[i].exp_addr);
      check("vec word", bus.o_instruction, vecs[i].word);
      tick();
      check("vec strobe off", 32'(bus.o_flag_write_intruc), 32'd0);
      check("vec done", 32'(bus.o_load_done), 32'(vecs[i].exp_done));
      check("vec count", 32'(bus.o_word_count), 32'(vecs[i].exp_count));
    end

    // Bytes in DONE are ignored.
    obs_q.delete();
    send_word(32'h5566_7788);
    idle(2);
    check("done nwrites", 32'(obs_q.size()), 32'd0);
    check("done count", 32'(bus.o_word_count), 32'd3);

    // Fill all 64 words back-to-back with non-halt bytes.
    pulse_start();
    obs_q.delete();
    stim_q.delete();
    for (int i = 0; i < 256; i++) stim_q.push_back(8'($urandom_range(254, 0)));
    foreach (stim_q[i]) send_byte(stim_q[i]);
    idle(2);
    build_model();
    compare_writes("fill");
    check("fill last addr", (obs_q.size() > 0) ? obs_q[obs_q.size()-1][63:32] : 32'hDEAD,
          32'd252);
    check("fill done", 32'(bus.o_load_done), 32'd1);
    check("fill count", 32'(bus.o_word_count), 32'd64);
    send_byte(8'h42);
    idle(2);
    check("fill extra nwrites", 32'(obs_q.size()), 32'd64);
    check("fill extra count", 32'(bus.o_word_count), 32'd64);

    // Restart mid-word discards the partial bytes.
    pulse_start();
    obs_q.delete();
    send_byte(8'h11);
    send_byte(8'h22);
    pulse_start();
    send_word(32'h1234_5678);
    idle(2);
    check("restart nwrites", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) begin
      check("restart addr", obs_q[0][63:32], 32'd0);
      check("restart word", obs_q[0][31:0], 32'h1234_5678);
    end

    // A byte during the WRITE cycle becomes byte 0 of the next word.
    pulse_start();
    obs_q.delete();
    send_word(32'h0102_0304);
    send_byte(8'hA5);
    send_byte(8'hB6);
    send_byte(8'hC7);
    send_byte(8'hD8);
    idle(2);
    check("wrbyte nwrites", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() > 1) begin
      check("wrbyte addr", obs_q[1][63:32], 32'd4);
      check("wrbyte word", obs_q[1][31:0], 32'hA5B6_C7D8);
    end
    check("wrbyte count", 32'(bus.o_word_count), 32'd2);

    // Synchronous reset after two bytes of a word.
    pulse_start();
    obs_q.delete();
    send_byte(8'h9A);
    send_byte(8'hBC);
    rst = 1'b1;
    @(negedge clk);
    check("rst strobe0", 32'(bus.o_flag_write_intruc), 32'd0);
    tick();
    rst = 1'b0;
    check("rst addr", bus.o_instruction_address, 32'h0);
    check("rst instr", bus.o_instruction, 32'h0);
    check("rst busy", 32'(bus.o_busy), 32'd0);
    check("rst count", 32'(bus.o_word_count), 32'd0);
    @(negedge clk);
    check("rst strobe1", 32'(bus.o_flag_write_intruc), 32'd0);
    tick();
    pulse_start();
    send_word(32'hCAFE_F00D);
    @(negedge clk);
    check("post-rst addr", bus.o_instruction_address, 32'd0);
    check("post-rst word", bus.o_instruction, 32'hCAFE_F00D);
    idle(2);

    // Inter-byte timeout.
    pulse_start();
    obs_q.delete();
    send_byte(8'h99);
`ifdef LOADER_TIMEOUT_EN
    idle(TmoCycles - 1);
    check("tmo early", 32'(bus.o_timeout_err), 32'd0);
    tick();
    check("tmo pulse", 32'(bus.o_timeout_err), 32'd1);
    tick();
    check("tmo one cycle", 32'(bus.o_timeout_err), 32'd0);
    send_word(32'hAABB_CCDD);
    idle(2);
    check("tmo nwrites", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) begin
      check("tmo addr", obs_q[0][63:32], 32'd0);
      check("tmo word", obs_q[0][31:0], 32'hAABB_CCDD);
    end
`else
    idle(TmoCycles + 4);
    check("no tmo pulse", 32'(bus.o_timeout_err), 32'd0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    idle(2);
    check("held nwrites", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) begin
      check("held addr", obs_q[0][63:32], 32'd0);
      check("held word", obs_q[0][31:0], 32'h99AA_BBCC);
    end
`endif

    // Randomized sessions against the reference model.
    for (int s = 0; s < 6; s++) run_session($urandom_range(20, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Byte-to-word loader upstream of the fetch stage. Assembles serial bytes from the UART receiver into 32-bit instructions and writes them sequentially into instruction memory. It drives the fetch stage's i_instruction_address, i_instruction and i_flag_write_intruc inputs. Loading ends on a halt word or when memory is full; the loader then flags done to the debug controller.

Parameters:
BITS_SIZE, 32, instruction and address width
SIZE_TOTAL, 256, instruction memory size in bytes (64 words)
HALT_WORD, 32'hFFFFFFFF, terminating instruction; it is written to memory and then the load ends
TIMEOUT_CYCLES, 1000000, inter-byte timeout; used only with LOADER_TIMEOUT_EN

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_load_start  in  1  one-cycle pulse; starts or restarts a load at address 0
i_rx_data  in  8  received byte
i_rx_valid  in  1  one-cycle pulse; i_rx_data is valid this cycle
o_instruction_address  out  BITS_SIZE  byte address of the word being written
o_instruction  out  BITS_SIZE  assembled instruction word
o_flag_write_intruc  out  1  one-cycle write strobe to instruction memory
o_busy  out  1  high in RECV and WRITE
o_load_done  out  1  level; high while in DONE
o_word_count  out  $clog2(SIZE_TOTAL/4)+1 (7)  number of words written in the current load
o_timeout_err  out  1  one-cycle pulse; partial word discarded

Behaviour:
- Reset: state IDLE. All outputs are 0. Byte index 0, word count 0, address 0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE: i_load_start -> RECV with address 0, count 0, byte index 0. i_rx_valid is ignored, including when it coincides with i_load_start.
- RECV, byte capture (i_rx_valid):
  - Big-endian assembly: the first byte goes to bits [31:24], the fourth byte to bits [7:0].
  - Byte index increments 0..3.
  - On the 4th byte: the full word is registered into o_instruction and the state moves to WRITE.
- WRITE (exactly one cycle):
  - o_flag_write_intruc=1, o_instruction_address is the current address, o_instruction holds the word.
  - Next cycle: address += 4, o_word_count += 1, strobe returns to 0.
  - Go to DONE if the word equals HALT_WORD or the address just written is SIZE_TOTAL-4 (memory full). Otherwise return to RECV.
  - i_rx_valid during WRITE is accepted as byte 0 of the next word (no byte lost). It is discarded if WRITE leads to DONE.
- DONE: o_load_done=1. Address and count hold their values. Bytes are ignored. i_load_start -> RECV, clearing address, count and o_load_done.
- i_load_start in RECV or WRITE: restart at address 0, discard the partial word. A write strobe in progress during WRITE still completes this cycle; address and count are then cleared.
- Write latency: the strobe is asserted the cycle after the 4th byte's i_rx_valid.
- o_instruction and o_instruction_address hold their last values outside WRITE.
- Address arithmetic: BITS_SIZE-bit, step 4, never exceeds SIZE_TOTAL-4.
- Reset mid-operation: immediate return to IDLE. Partial data and count are lost. No strobe is issued in the reset cycle or the cycle after.

Optional Feature:
LOADER_TIMEOUT_EN
- Defined:
  - An inter-byte counter runs in RECV while byte index ≠ 0 and clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES: byte index is set to 0, the partial word is discarded, o_timeout_err pulses for 1 cycle, and the state stays RECV.
  - Address and count are unchanged.
- Undefined: no counter; a partial word is held indefinitely; o_timeout_err is tied to 0.

Test Plan:
- Pulse i_load_start, then send bytes 20 01 00 05, 00 00 00 00, FF FF FF FF -> three strobes with (addr, word) = (0, 0x20010005), (4, 0x00000000), (8, 0xFFFFFFFF). Then o_load_done=1 and o_word_count=3.
- Send 256 non-halt bytes -> 64 strobes, the last at address 252. DONE follows; a further byte causes no strobe and o_word_count=64.
- Send bytes 11 22, then pulse i_load_start, then send 12 34 56 78 -> a single strobe at address 0 with word 0x12345678.
- Send i_rx_valid in IDLE and DONE -> no strobe and no count change. Send a byte in the WRITE cycle -> it becomes bits [31:24] of the next word.
- Assert i_reset during RECV after 2 bytes -> all outputs 0, IDLE. A subsequent load starts cleanly at address 0.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 1 byte, idle 16 cycles -> o_timeout_err pulse. Then send AA BB CC DD -> strobe with word 0xAABBCCDD at address 0.
